// File: rtl/keypad_pkg.sv
// Shared types, column drive constants and key coding for the keypad scanner.
`timescale 1ns/1ps
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_EMIT         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    // One-cold column drives: the single low bit selects the active column.
    localparam logic [3:0] COL0_DRIVE = 4'b1110;
    localparam logic [3:0] COL1_DRIVE = 4'b1101;
    localparam logic [3:0] COL2_DRIVE = 4'b1011;
    localparam logic [3:0] COL3_DRIVE = 4'b0111;

    // Synchronized row value when no key in the driven column is pressed.
    localparam logic [3:0] ROWS_IDLE  = 4'hF;

    function automatic logic [3:0] col_onecold(input logic [1:0] c);
        logic [3:0] drive;
        case (c)
            2'd0:    drive = COL0_DRIVE;
            2'd1:    drive = COL1_DRIVE;
            2'd2:    drive = COL2_DRIVE;
            default: drive = COL3_DRIVE;
        endcase
        return drive;
    endfunction

    // Key code as seen by the lock: row in the upper bits, column in the lower.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

    // True when exactly one active-low row is asserted.
    function automatic logic single_low(input logic [3:0] rows);
        return (rows == 4'b1110) || (rows == 4'b1101) ||
               (rows == 4'b1011) || (rows == 4'b0111);
    endfunction

    // Index of the low row; only meaningful when single_low() holds.
    function automatic logic [1:0] low_row_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all-ones.
`timescale 1ns/1ps
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Metastability settling stage followed by the clean output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, key strobes.
`timescale 1ns/1ps
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_drive,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_error
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       rows;
    state_t           state, state_n;
    logic [1:0]       col, col_n;
    logic [DIV_W-1:0] dwell, dwell_n;
    logic [DEB_W-1:0] deb, deb_n;
    logic [3:0]       pattern, pattern_n;
    logic [3:0]       key_n;
    logic             key_valid_n, key_error_n;

    sync_2ff #(
        .WIDTH (4)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (rows)
    );

    assign col_drive = col_onecold(col);

    // State, counters and registered outputs; reset aborts any press in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_SCAN;
            col       <= 2'd0;
            dwell     <= '0;
            deb       <= '0;
            pattern   <= ROWS_IDLE;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_error <= 1'b0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            dwell     <= dwell_n;
            deb       <= deb_n;
            pattern   <= pattern_n;
            key       <= key_n;
            key_valid <= key_valid_n;
            key_error <= key_error_n;
        end
    end

    // Next-state logic: scan columns, debounce the captured pattern, emit once, wait for release.
    always_comb begin
        state_n     = state;
        col_n       = col;
        dwell_n     = dwell;
        deb_n       = deb;
        pattern_n   = pattern;
        key_n       = key;
        key_valid_n = 1'b0;
        key_error_n = 1'b0;

        case (state)
            ST_SCAN: begin
                if (dwell == DIV_LAST) begin
                    dwell_n = '0;
                    if (rows == ROWS_IDLE) begin
                        col_n = col + 2'd1;
                    end else begin
                        pattern_n = rows;
                        deb_n     = '0;
                        state_n   = ST_DEBOUNCE;
                    end
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end

            ST_DEBOUNCE: begin
                if (rows != pattern) begin
                    // Bounce or early release: give up on this column and move on.
                    state_n = ST_SCAN;
                    col_n   = col + 2'd1;
                    dwell_n = '0;
                    deb_n   = '0;
                end else if (deb == DEB_LAST) begin
                    state_n = ST_EMIT;
                end else begin
                    deb_n = deb + 1'b1;
                end
            end

            ST_EMIT: begin
                // The captured pattern equalled rows on every debounce cycle.
                if (single_low(pattern)) begin
                    key_n       = key_code(low_row_index(pattern), col);
                    key_valid_n = 1'b1;
                end else begin
                    key_error_n = 1'b1;
                end
                deb_n   = '0;
                state_n = ST_WAIT_RELEASE;
            end

            ST_WAIT_RELEASE: begin
                if (rows != ROWS_IDLE) begin
                    deb_n = '0;
                end else if (deb == DEB_LAST) begin
                    state_n = ST_SCAN;
                    col_n   = col + 2'd1;
                    dwell_n = '0;
                    deb_n   = '0;
                end else begin
                    deb_n = deb + 1'b1;
                end
            end

            default: begin
                state_n = ST_SCAN;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a behavioural 4x4 keypad.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_drive;
    logic [3:0] key;
    logic       key_valid;
    logic       key_error;

    // Keypad model: kp_rows appears on the row lines only while column kp_col is driven low.
    logic       kp_en;
    logic [1:0] kp_col;
    logic [3:0] kp_rows;

    assign row_in = (kp_en && (col_drive[kp_col] == 1'b0)) ? kp_rows : 4'hF;

    int checks;
    int failures;
    int valid_cnt;
    int err_cnt;
    int viol;
    bit prev_strobe;
    logic [3:0] keyq[$];

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_drive (col_drive),
        .key       (key),
        .key_valid (key_valid),
        .key_error (key_error)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Advance n cycles, sampling outputs on each falling edge and tallying strobes.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (key_valid) begin
                valid_cnt++;
                keyq.push_back(key);
            end
            if (key_error) err_cnt++;
            if (key_valid && key_error) viol++;
            if ((key_valid || key_error) && prev_strobe) viol++;
            prev_strobe = key_valid || key_error;
        end
    endtask

    task automatic wait_strobe(input bit want_err, input int budget, output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            cycles++;
            if (want_err ? key_error : key_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_col(input logic [3:0] drive, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (col_drive == drive) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        kp_en = 1'b0;
        tick(3);
        checks++;
        if (col_drive !== 4'b1110) begin failures++; $display("FAIL reset_col col_drive=%b required=1110", col_drive); end
        checks++;
        if (key !== 4'h0) begin failures++; $display("FAIL reset_key key=%h required=0", key); end
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid key_valid=%b required=0", key_valid); end
        checks++;
        if (key_error !== 1'b0) begin failures++; $display("FAIL reset_error key_error=%b required=0", key_error); end
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_cols [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        int v0, e0;
        v0  = valid_cnt;
        e0  = err_cnt;
        rst = 1'b0;
        // Column advances on the SCAN_DIV-th edge after release; sample mid-dwell.
        tick(2);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (col_drive !== exp_cols[k])
                begin failures++; $display("FAIL idle_col%0d col_drive=%b required=%b", k, col_drive, exp_cols[k]); end
            tick(4);
        end
        tick(18);
        checks++;
        if (valid_cnt != v0) begin failures++; $display("FAIL idle_valid strobes=%0d required=0", valid_cnt - v0); end
        checks++;
        if (err_cnt != e0) begin failures++; $display("FAIL idle_error strobes=%0d required=0", err_cnt - e0); end
    endtask

    task automatic test_press_hold();
        bit seen;
        int cyc, v0;
        wait_col(4'b1101, 50, seen);
        kp_rows = 4'b1101;
        kp_col  = 2'd2;
        kp_en   = 1'b1;
        wait_col(4'b1011, 50, seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL press_col2 col_drive=%b required=1011", col_drive); end
        v0 = valid_cnt;
        wait_strobe(1'b0, 200, seen, cyc);
        checks++;
        if (!seen) begin failures++; $display("FAIL press_timeout key_valid=0 required=1"); end
        // Column select, SCAN_DIV dwell edges, then DEBOUNCE_CYCLES+1 to the strobe.
        checks++;
        if (cyc != SCAN_DIV + DEBOUNCE_CYCLES + 1)
            begin failures++; $display("FAIL press_latency cycles=%0d required=%0d", cyc, SCAN_DIV + DEBOUNCE_CYCLES + 1); end
        checks++;
        if (key !== 4'h6) begin failures++; $display("FAIL press_key key=%h required=6", key); end
        checks++;
        if (key_error !== 1'b0) begin failures++; $display("FAIL press_noerr key_error=%b required=0", key_error); end
        tick(100);
        checks++;
        if (valid_cnt != v0 + 1) begin failures++; $display("FAIL hold_nostrobe strobes=%0d required=1", valid_cnt - v0); end
        kp_en = 1'b0;
        tick(25);
        kp_rows = 4'b0111;
        kp_col  = 2'd3;
        kp_en   = 1'b1;
        wait_strobe(1'b0, 200, seen, cyc);
        checks++;
        if (!seen) begin failures++; $display("FAIL press2_timeout key_valid=0 required=1"); end
        checks++;
        if (key !== 4'hF) begin failures++; $display("FAIL press2_key key=%h required=f", key); end
        kp_en = 1'b0;
        tick(25);
        checks++;
        if (valid_cnt != v0 + 2) begin failures++; $display("FAIL press2_count strobes=%0d required=2", valid_cnt - v0); end
    endtask

    task automatic test_bounce();
        bit seen;
        int cyc, v0, e0;
        v0      = valid_cnt;
        e0      = err_cnt;
        kp_rows = 4'b1011;
        kp_col  = 2'd0;
        for (int i = 0; i < 10; i++) begin
            kp_en = (i % 2 == 0);
            tick(3);
        end
        checks++;
        if (valid_cnt != v0 || err_cnt != e0)
            begin failures++; $display("FAIL bounce_quiet strobes=%0d required=0", (valid_cnt - v0) + (err_cnt - e0)); end
        kp_en = 1'b1;
        wait_strobe(1'b0, 200, seen, cyc);
        checks++;
        if (!seen) begin failures++; $display("FAIL bounce_timeout key_valid=0 required=1"); end
        checks++;
        if (key !== 4'h8) begin failures++; $display("FAIL bounce_key key=%h required=8", key); end
        tick(20);
        checks++;
        if (valid_cnt != v0 + 1) begin failures++; $display("FAIL bounce_once strobes=%0d required=1", valid_cnt - v0); end
        kp_en = 1'b0;
        tick(25);
    endtask

    task automatic test_multi_row_error();
        bit seen;
        int cyc, v0, e0;
        v0      = valid_cnt;
        e0      = err_cnt;
        kp_rows = 4'b1010;
        kp_col  = 2'd1;
        kp_en   = 1'b1;
        wait_strobe(1'b1, 200, seen, cyc);
        checks++;
        if (!seen) begin failures++; $display("FAIL error_timeout key_error=0 required=1"); end
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("FAIL error_novalid key_valid=%b required=0", key_valid); end
        checks++;
        if (key !== 4'h8) begin failures++; $display("FAIL error_keyhold key=%h required=8", key); end
        tick(1);
        checks++;
        if (key_error !== 1'b0) begin failures++; $display("FAIL error_onecycle key_error=%b required=0", key_error); end
        tick(20);
        checks++;
        if (err_cnt != e0 + 1 || valid_cnt != v0)
            begin failures++; $display("FAIL error_counts errors=%0d valids=%0d required=1,0", err_cnt - e0, valid_cnt - v0); end
        kp_en = 1'b0;
        tick(25);
    endtask

    task automatic test_reset_abort();
        bit seen;
        int cyc, v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        wait_col(4'b1011, 50, seen);
        kp_rows = 4'b1110;
        kp_col  = 2'd3;
        kp_en   = 1'b1;
        wait_col(4'b0111, 50, seen);
        // Seven edges into the column: press captured, debounce in progress.
        tick(7);
        #0.3 rst = 1'b1;
        #0.2;
        checks++;
        if (col_drive !== 4'b1110) begin failures++; $display("FAIL abort_deb_col col_drive=%b required=1110", col_drive); end
        checks++;
        if (key !== 4'h0) begin failures++; $display("FAIL abort_deb_key key=%h required=0", key); end
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("FAIL abort_deb_valid key_valid=%b required=0", key_valid); end
        tick(3);
        rst = 1'b0;
        tick(3);
        checks++;
        if (col_drive !== 4'b1110) begin failures++; $display("FAIL abort_deb_restart col_drive=%b required=1110", col_drive); end
        checks++;
        if (valid_cnt != v0) begin failures++; $display("FAIL abort_deb_nostrobe strobes=%0d required=0", valid_cnt - v0); end
        wait_strobe(1'b0, 200, seen, cyc);
        checks++;
        if (!seen) begin failures++; $display("FAIL abort_press_timeout key_valid=0 required=1"); end
        checks++;
        if (key !== 4'h3) begin failures++; $display("FAIL abort_press_key key=%h required=3", key); end
        tick(5);
        #0.3 rst = 1'b1;
        #0.2;
        checks++;
        if (key !== 4'h0) begin failures++; $display("FAIL abort_wr_key key=%h required=0", key); end
        checks++;
        if (col_drive !== 4'b1110) begin failures++; $display("FAIL abort_wr_col col_drive=%b required=1110", col_drive); end
        kp_en = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(20);
        checks++;
        if (valid_cnt != v0 + 1 || err_cnt != e0)
            begin failures++; $display("FAIL abort_wr_counts valids=%0d errors=%0d required=1,0", valid_cnt - v0, err_cnt - e0); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] codes [4] = '{4'h4, 4'hD, 4'hD, 4'hC};
        logic [3:0] code;
        bit seen;
        int cyc, q0;
        q0 = keyq.size();
        for (int i = 0; i < 4; i++) begin
            code    = codes[i];
            kp_rows = ~(4'b0001 << code[3:2]);
            kp_col  = code[1:0];
            kp_en   = 1'b1;
            wait_strobe(1'b0, 200, seen, cyc);
            checks++;
            if (!seen || key !== code)
                begin failures++; $display("FAIL seq_key%0d key=%h seen=%0d required=%h", i, key, seen, code); end
            kp_en = 1'b0;
            tick(25);
        end
        checks++;
        if (keyq.size() != q0 + 4)
            begin failures++; $display("FAIL seq_count strobes=%0d required=4", keyq.size() - q0); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (keyq[q0 + i] !== codes[i])
                    begin failures++; $display("FAIL seq_order%0d key=%h required=%h", i, keyq[q0 + i], codes[i]); end
            end
        end
    endtask

    task automatic test_strobe_rules();
        checks++;
        if (viol != 0) begin failures++; $display("FAIL strobe_rules violations=%0d required=0", viol); end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        valid_cnt   = 0;
        err_cnt     = 0;
        viol        = 0;
        prev_strobe = 1'b0;
        rst         = 1'b1;
        kp_en       = 1'b0;
        kp_col      = 2'd0;
        kp_rows     = 4'hF;
        test_reset();
        test_idle_scan();
        test_press_hold();
        test_bounce();
        test_multi_row_error();
        test_reset_abort();
        test_back_to_back();
        test_strobe_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each column is driven during scanning (min 4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 20000: consecutive stable cycles required for a press or a release (min 2).
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 row_in  input  4  keypad rows, active-low (board pull-ups), asynchronous to clk.
REQ-006 col_drive  output  4  keypad columns, active-low, exactly one bit low at all times.
REQ-007 key  output  4  code of the last accepted key, = row_index*4 + col_index; feeds the lock's key input.
REQ-008 key_valid  output  1  one-cycle strobe: key updated with a new press.
REQ-009 key_error  output  1  one-cycle strobe: a debounced press had more than one row low.

Function
REQ-010 row_in SHALL pass through a 2-flop synchronizer before any use; "rows" below means the synchronized value.
REQ-011 FSM states SHALL be SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
REQ-012 SCAN: drive column c for SCAN_DIV cycles, with dwell counter 0..SCAN_DIV-1.
REQ-013 At dwell count SCAN_DIV-1 in SCAN, rows == 4'hF SHALL advance c to (c+1) mod 4 and clear the counter (3 wraps to 0).
REQ-014 At that same sample, rows != 4'hF SHALL capture the row pattern, hold column c, clear the debounce counter and enter DEBOUNCE.
REQ-015 DEBOUNCE: each cycle rows equal the captured pattern, increment the counter; on reaching DEBOUNCE_CYCLES-1, enter EMIT.
REQ-016 DEBOUNCE: any cycle rows differ from the captured pattern (including all-high), return to SCAN at column (c+1) mod 4, no strobe.
REQ-017 EMIT, one cycle: exactly one row r low SHALL load key <= {r[1:0], c[1:0]} and pulse key_valid.
REQ-018 EMIT, one cycle: more than one row low SHALL pulse key_error and leave key unchanged.
REQ-019 Both EMIT cases then SHALL enter WAIT_RELEASE.
REQ-020 WAIT_RELEASE: hold column c; count consecutive cycles with rows == 4'hF; any low row clears the count.
REQ-021 WAIT_RELEASE: on reaching DEBOUNCE_CYCLES-1, enter SCAN at column (c+1) mod 4; a held key SHALL never re-strobe.
REQ-022 key_valid and key_error SHALL never assert in the same cycle and SHALL never be high for two consecutive cycles.
REQ-023 key SHALL hold its value between strobes.
REQ-024 Latency from the first synchronized stable-low sample in SCAN to key_valid: DEBOUNCE_CYCLES+1 cycles.
REQ-025 Counters SHALL be sized $clog2 of their parameter and SHALL never wrap past their terminal value.

Reset
REQ-026 While rst=1: state SCAN, c=0, col_drive=4'b1110, key=4'h0, key_valid=0, key_error=0, all counters 0, synchronizer flops 4'hF.
REQ-027 Reset asserted in any state, including DEBOUNCE or WAIT_RELEASE, SHALL abort immediately with no strobe.
REQ-028 The first scan sample after reset release SHALL occur SCAN_DIV cycles later.

Structure
REQ-029 Shared package keypad_pkg SHALL hold the state enum, the column one-cold constants and the row/col-to-code mapping function.
REQ-030 The synchronizer SHALL be sub-module sync_2ff (parameter WIDTH, reset value all-ones), instantiated once with WIDTH=4.
REQ-031 Target size: 150-300 lines of RTL.

Verification (bench: SCAN_DIV=4, DEBOUNCE_CYCLES=8, clk period 2 ns)
REQ-032 Reset then idle (row_in=4'hF) for 40 cycles -> col_drive cycles 1110,1101,1011,0111,1110 every 4 cycles; no strobes.
REQ-033 Hold row 1 low (4'b1101) while column 2 is driven -> single key_valid, key=4'h6 (1*4+2); held 100 cycles -> no further strobe; release, then next press of row3/col3 -> key=4'hF.
REQ-034 Bounce: row pattern toggling every 3 cycles for 30 cycles, then stable -> no strobe during bounce; exactly one key_valid after stable DEBOUNCE_CYCLES.
REQ-035 Rows 0 and 2 low (4'b1010) on column 1 -> key_error one cycle; key keeps its prior value; no key_valid.
REQ-036 rst pulsed mid-DEBOUNCE and mid-WAIT_RELEASE -> outputs return to reset values asynchronously; no strobe; scanning restarts at column 0.
REQ-037 Integration: scanner key/key_valid drive the lock block with the sequence 4'h4, 4'hD, 4'hD, 4'hC -> scanner emits exactly four key_valid strobes in that order.
